// File: rtl/cook_sequencer.sv
// Egg-timer run-control sequencer: owns the cook-time preset, drives the
// BCD countdown timer (load / count_en) and runs the timed blinking alarm.
//
// Ports:
//   CLK100MHZ   in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   tick_1hz    in   one-cycle strobe per second
//   set_mode    in   level, cook-time edit requested
//   start_btn   in   debounced, rising edge = start/resume
//   stop_btn    in   debounced, rising edge = pause/cancel/ack
//   min_up      in   debounced, rising edge = minutes +1
//   sec_up      in   debounced, rising edge = seconds +1
//   cur_time    in   timer value {mt, mo, st, so} BCD
//   load        out  one-cycle pulse, timer takes load_time
//   load_time   out  preset value, same BCD packing
//   count_en    out  timer decrement enable (combinational)
//   alarm       out  high while in ALARM
//   alarm_blink out  toggles each second in ALARM
//   state       out  IDLE=0 SET=1 RUN=2 PAUSE=3 ALARM=4
module cook_sequencer #(
    parameter int unsigned ALARM_SECONDS = 10
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        set_mode,
    input  logic        start_btn,
    input  logic        stop_btn,
    input  logic        min_up,
    input  logic        sec_up,
    input  logic [15:0] cur_time,
    output logic        load,
    output logic [15:0] load_time,
    output logic        count_en,
    output logic        alarm,
    output logic        alarm_blink,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    localparam logic [7:0] LP_ALARM = 8'(ALARM_SECONDS);

    state_t      r_state;
    logic [15:0] r_preset;
    logic        r_load;
    logic        r_alarm;
    logic        r_blink;
    logic [7:0]  r_cnt;
    logic        r_first;
    logic        r_edit_pend;
    logic        r_start_q;
    logic        r_stop_q;
    logic        r_min_q;
    logic        r_sec_q;

    state_t      w_nxt;
    logic [15:0] w_preset_nxt;
    logic        w_load_nxt;
    logic        w_blink_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_cnt_inc;
    logic        w_first_nxt;
    logic        w_edit;
    logic        w_start_rise;
    logic        w_stop_rise;
    logic        w_min_rise;
    logic        w_sec_rise;

    function automatic logic [7:0] f_min_inc(input logic [7:0] m);
        logic [3:0] v_t;
        logic [3:0] v_o;
        v_t = m[7:4];
        v_o = m[3:0];
        if (v_o == 4'd9) begin
            v_o = 4'd0;
            v_t = (v_t == 4'd9) ? 4'd0 : v_t + 4'd1;
        end else begin
            v_o = v_o + 4'd1;
        end
        return {v_t, v_o};
    endfunction

    // Seconds wrap at 59 with no carry into minutes.
    function automatic logic [7:0] f_sec_inc(input logic [7:0] s);
        logic [3:0] v_t;
        logic [3:0] v_o;
        v_t = s[7:4];
        v_o = s[3:0];
        if (s == 8'h59) begin
            v_t = 4'd0;
            v_o = 4'd0;
        end else if (v_o == 4'd9) begin
            v_o = 4'd0;
            v_t = v_t + 4'd1;
        end else begin
            v_o = v_o + 4'd1;
        end
        return {v_t, v_o};
    endfunction

    assign w_start_rise = start_btn & ~r_start_q;
    assign w_stop_rise  = stop_btn & ~r_stop_q;
    assign w_min_rise   = min_up & ~r_min_q;
    assign w_sec_rise   = sec_up & ~r_sec_q;
    assign w_cnt_inc    = r_cnt + 8'd1;

    always_comb begin
        w_nxt        = r_state;
        w_preset_nxt = r_preset;
        w_load_nxt   = r_edit_pend;
        w_blink_nxt  = r_blink;
        w_cnt_nxt    = r_cnt;
        w_first_nxt  = 1'b0;
        w_edit       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (set_mode) begin
                    w_nxt = ST_SET;
                end else if (w_start_rise && r_preset != 16'h0000) begin
                    w_nxt       = ST_RUN;
                    w_load_nxt  = 1'b1;
                    w_first_nxt = 1'b1;
                end
            end
            ST_SET: begin
                if (w_min_rise) begin
                    w_preset_nxt[15:8] = f_min_inc(r_preset[15:8]);
                end
                if (w_sec_rise) begin
                    w_preset_nxt[7:0] = f_sec_inc(r_preset[7:0]);
                end
                w_edit = w_min_rise | w_sec_rise;
                if (!set_mode) begin
                    w_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_stop_rise) begin
                    w_nxt = ST_PAUSE;
                end else if (!r_first && cur_time == 16'h0000) begin
                    // First RUN cycle after a load still sees the old value.
                    w_nxt       = ST_ALARM;
                    w_blink_nxt = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_PAUSE: begin
                if (w_stop_rise) begin
                    w_nxt      = ST_IDLE;
                    w_load_nxt = 1'b1;
                end else if (w_start_rise) begin
                    w_nxt = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (w_stop_rise || w_start_rise ||
                    (tick_1hz && w_cnt_inc == LP_ALARM)) begin
                    w_nxt       = ST_IDLE;
                    w_load_nxt  = 1'b1;
                    w_blink_nxt = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end else if (tick_1hz) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_blink_nxt = ~r_blink;
                end
            end
            default: begin
                w_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_preset    <= 16'h0000;
            r_load      <= 1'b0;
            r_alarm     <= 1'b0;
            r_blink     <= 1'b0;
            r_cnt       <= 8'd0;
            r_first     <= 1'b0;
            r_edit_pend <= 1'b0;
            // Held buttons must not fire on reset release.
            r_start_q   <= 1'b1;
            r_stop_q    <= 1'b1;
            r_min_q     <= 1'b1;
            r_sec_q     <= 1'b1;
        end else begin
            r_state     <= w_nxt;
            r_preset    <= w_preset_nxt;
            r_load      <= w_load_nxt;
            r_alarm     <= (w_nxt == ST_ALARM);
            r_blink     <= w_blink_nxt;
            r_cnt       <= w_cnt_nxt;
            r_first     <= w_first_nxt;
            r_edit_pend <= w_edit;
            r_start_q   <= start_btn;
            r_stop_q    <= stop_btn;
            r_min_q     <= min_up;
            r_sec_q     <= sec_up;
        end
    end

    assign count_en    = (r_state == ST_RUN) && (cur_time != 16'h0000);
    assign load        = r_load;
    assign load_time   = r_preset;
    assign alarm       = r_alarm;
    assign alarm_blink = r_blink;
    assign state       = r_state;

endmodule

// File: tb/tb_cook_sequencer.sv
// Scoreboard bench for cook_sequencer with a behavioural BCD timer.
// Load pulses are checked by a monitor against queued expectations.
module tb_cook_sequencer;

    logic        clk;
    logic        reset;
    logic        tick_1hz;
    logic        set_mode;
    logic        start_btn;
    logic        stop_btn;
    logic        min_up;
    logic        sec_up;
    logic [15:0] cur_time;
    logic        load;
    logic [15:0] load_time;
    logic        count_en;
    logic        alarm;
    logic        alarm_blink;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    cook_sequencer #(.ALARM_SECONDS(3)) dut (
        .CLK100MHZ  (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .set_mode   (set_mode),
        .start_btn  (start_btn),
        .stop_btn   (stop_btn),
        .min_up     (min_up),
        .sec_up     (sec_up),
        .cur_time   (cur_time),
        .load       (load),
        .load_time  (load_time),
        .count_en   (count_en),
        .alarm      (alarm),
        .alarm_blink(alarm_blink),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] tdec(input logic [15:0] t);
        int total;
        total = (int'(t[15:12]) * 10 + int'(t[11:8])) * 60
              + int'(t[7:4]) * 10 + int'(t[3:0]);
        if (total > 0) total = total - 1;
        return {bcd2(total / 60), bcd2(total % 60)};
    endfunction

    // Behavioural countdown timer feeding cur_time.
    initial cur_time = 16'h0000;
    always @(posedge clk) begin
        if (load) cur_time <= load_time;
        else if (count_en && tick_1hz) cur_time <= tdec(cur_time);
    end

    // Monitor: every load pulse must match the next queued preset.
    always @(negedge clk) begin
        if (reset && load) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected got %h required none",
                         load_time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (load_time !== e) begin
                    errors++;
                    $display("FAIL load_time got %h required %h",
                             load_time, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        start_btn = 1'b1; step(1);
        start_btn = 1'b0; step(1);
    endtask

    task automatic press_stop();
        stop_btn = 1'b1; step(1);
        stop_btn = 1'b0; step(1);
    endtask

    task automatic press_min();
        min_up = 1'b1; step(1);
        min_up = 1'b0; step(1);
    endtask

    task automatic press_sec();
        sec_up = 1'b1; step(1);
        sec_up = 1'b0; step(1);
    endtask

    task automatic tick();
        tick_1hz = 1'b1; step(1);
        tick_1hz = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        tick_1hz  = 1'b0;
        set_mode  = 1'b0;
        start_btn = 1'b1;
        stop_btn  = 1'b0;
        min_up    = 1'b0;
        sec_up    = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
        check("rst_state", 16'(state), 16'd0);
        check("rst_load", 16'(load), 16'd0);
        check("rst_count_en", 16'(count_en), 16'd0);
        check("rst_alarm", 16'(alarm), 16'd0);
        check("rst_blink", 16'(alarm_blink), 16'd0);
        check("rst_preset", load_time, 16'h0000);
        start_btn = 1'b0; step(1);
        press_start();
        check("idle_zero_start", 16'(state), 16'd0);

        // Edit preset to 03:02 (seconds wrap after 59).
        set_mode = 1'b1; step(1);
        check("enter_set", 16'(state), 16'd1);
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back({bcd2(k), 8'h00});
            press_min();
        end
        for (int k = 1; k <= 62; k++) begin
            exp_q.push_back({8'h03, bcd2(k % 60)});
            press_sec();
        end
        check("preset_0302", load_time, 16'h0302);
        // Minutes 03 -> 99 -> 00 wrap.
        for (int k = 1; k <= 97; k++) begin
            exp_q.push_back({bcd2((3 + k) % 100), 8'h02});
            press_min();
        end
        check("preset_0002", load_time, 16'h0002);
        set_mode = 1'b0; step(1);
        check("set_exit", 16'(state), 16'd0);

        // Run 00:02 down to alarm.
        exp_q.push_back(16'h0002);
        press_start();
        check("run_state", 16'(state), 16'd2);
        check("run_count_en", 16'(count_en), 16'd1);
        tick();
        check("run_after_tick", 16'(state), 16'd2);
        tick();
        check("zero_count_en", 16'(count_en), 16'd0);
        check("zero_still_run", 16'(state), 16'd2);
        step(1);
        check("alarm_state", 16'(state), 16'd4);
        check("alarm_on", 16'(alarm), 16'd1);
        check("blink_entry", 16'(alarm_blink), 16'd1);
        check("alarm_count_en", 16'(count_en), 16'd0);
        tick();
        check("blink_t1", 16'(alarm_blink), 16'd0);
        check("alarm_t1", 16'(state), 16'd4);
        tick();
        check("blink_t2", 16'(alarm_blink), 16'd1);
        exp_q.push_back(16'h0002);
        tick();
        check("alarm_done_state", 16'(state), 16'd0);
        check("alarm_done_alarm", 16'(alarm), 16'd0);
        check("alarm_done_blink", 16'(alarm_blink), 16'd0);
        step(1);

        // Preset 01:05 with a simultaneous min+sec edit.
        set_mode = 1'b1; step(1);
        exp_q.push_back(16'h0103);
        min_up = 1'b1; sec_up = 1'b1; step(1);
        min_up = 1'b0; sec_up = 1'b0; step(1);
        check("simul_edit", load_time, 16'h0103);
        exp_q.push_back(16'h0104);
        press_sec();
        exp_q.push_back(16'h0105);
        press_sec();
        set_mode = 1'b0; step(2);

        // Pause / resume / cancel.
        exp_q.push_back(16'h0105);
        press_start();
        check("run2_count_en", 16'(count_en), 16'd1);
        press_stop();
        check("pause_state", 16'(state), 16'd3);
        check("pause_count_en", 16'(count_en), 16'd0);
        tick();
        step(1);
        check("pause_held", cur_time, 16'h0105);
        press_start();
        check("resume_state", 16'(state), 16'd2);
        check("resume_count_en", 16'(count_en), 16'd1);
        press_stop();
        check("pause2_state", 16'(state), 16'd3);
        exp_q.push_back(16'h0105);
        press_stop();
        check("cancel_state", 16'(state), 16'd0);
        step(1);

        // Stop beats start in RUN.
        exp_q.push_back(16'h0105);
        press_start();
        tick();
        step(1);
        check("run_dec", cur_time, 16'h0104);
        start_btn = 1'b1; stop_btn = 1'b1; step(1);
        start_btn = 1'b0; stop_btn = 1'b0; step(1);
        check("stop_prio", 16'(state), 16'd3);
        exp_q.push_back(16'h0105);
        press_stop();
        step(1);

        // Full 65 s run, then stop coincident with tick in ALARM.
        exp_q.push_back(16'h0105);
        press_start();
        for (int k = 0; k < 65; k++) tick();
        step(1);
        check("alarm2_state", 16'(state), 16'd4);
        exp_q.push_back(16'h0105);
        stop_btn = 1'b1; tick_1hz = 1'b1; step(1);
        stop_btn = 1'b0; tick_1hz = 1'b0;
        check("ack_state", 16'(state), 16'd0);
        check("ack_alarm", 16'(alarm), 16'd0);
        check("ack_blink", 16'(alarm_blink), 16'd0);
        step(2);

        // Asynchronous reset mid-run.
        exp_q.push_back(16'h0105);
        press_start();
        check("run3_count_en", 16'(count_en), 16'd1);
        reset = 1'b0;
        #2;
        check("arst_state", 16'(state), 16'd0);
        check("arst_count_en", 16'(count_en), 16'd0);
        check("arst_preset", load_time, 16'h0000);
        step(1);
        reset = 1'b1;
        step(2);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
- Run-control sequencer for the egg timer countdown datapath.
- Owns the cook-time preset register and edits it from the minute/second buttons.
- Issues load and count-enable to the BCD countdown timer, watches its current value for 00:00, then runs a timed, blinking alarm.
- Sits between the debouncers and the timer/display; supplies pause/resume and alarm behaviour.

Parameters:
ALARM_SECONDS, 10, number of tick_1hz strobes the alarm stays active before auto-clear (1..255)

Ports:
CLK100MHZ  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
tick_1hz  input  1  one-CLK100MHZ-cycle strobe, once per second
set_mode  input  1  level; 1 = cook-time edit requested
start_btn  input  1  debounced level; rising edge = start/resume
stop_btn  input  1  debounced level; rising edge = pause/cancel/ack
min_up  input  1  debounced level; rising edge = minutes +1
sec_up  input  1  debounced level; rising edge = seconds +1
cur_time  input  16  timer value {min_tens, min_ones, sec_tens, sec_ones}, BCD
load  output  1  one-cycle pulse; timer takes load_time
load_time  output  16  preset value in the same BCD packing
count_en  output  1  timer decrement enable
alarm  output  1  high while in ALARM
alarm_blink  output  1  buzzer/LED drive; toggles each second in ALARM
state  output  3  IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4

Behaviour:
- Reset (async, reset=0): state IDLE, preset 00:00, load=0, count_en=0, alarm=0, alarm_blink=0, alarm counter 0.
- Button edge registers reset to 1, so a button held through reset release does not fire.
- Edge detect: rise = in & ~prev, sampled on CLK100MHZ. The action registers one cycle after the sampled rising edge.
- load_time always equals the preset register.
- IDLE:
  - set_mode=1 -> SET.
  - start rise with preset != 0000 -> load pulse in the same cycle as the transition to RUN.
  - start rise with preset = 0000 -> ignored.
- SET:
  - min_up rise -> minutes +1 BCD, 99 wraps to 00.
  - sec_up rise -> seconds +1 BCD, 59 wraps to 00, no carry into minutes.
  - Simultaneous min/sec rises both apply.
  - One cycle after any edit, load pulses so the display previews the preset.
  - set_mode=0 -> IDLE. start/stop are ignored.
- RUN:
  - count_en = 1 only while cur_time != 0000 (combinational gate, so the timer never underflows).
  - Zero check is suppressed in the first RUN cycle after a load. Afterwards cur_time = 0000 -> ALARM.
  - stop rise -> PAUSE.
- PAUSE:
  - count_en=0; cur_time is held by the timer.
  - start rise -> RUN with no load.
  - stop rise -> IDLE with a load pulse that restores the preset.
- ALARM:
  - alarm=1, count_en=0; alarm_blink=1 on entry, toggles on each tick_1hz.
  - The counter increments per tick. When it reaches ALARM_SECONDS -> IDLE.
  - A start or stop rise -> IDLE immediately.
  - Exit from ALARM: alarm=0, alarm_blink=0, counter cleared, one load pulse with the preset (re-arm).
- Priority on the same cycle: stop rise > start rise > tick/zero event.
- set_mode is ignored outside IDLE/SET. The preset persists across runs until edited or reset.
- Reset mid-run: immediate IDLE, preset cleared, count_en drops asynchronously.
- All outputs are registered except count_en.

Test Plan:
- Reset low with start_btn held high, release -> state=0, no load, outputs 0; releasing and re-pressing start with preset 0000 keeps state IDLE.
- set_mode=1, 3x min_up, 62x sec_up -> preset 0302 (seconds wrapped at 60); a load pulse follows each edit; set_mode=0 -> IDLE.
- Preset 0002, start -> one load cycle with load_time=0002, RUN; model timer decrements on ticks; at 0000 count_en drops same cycle, next cycle state=4, alarm=1.
- In ALARM with ALARM_SECONDS=3: alarm_blink 1,0,1 across ticks; after 3rd tick -> IDLE, alarm=0, load pulse with preset.
- RUN at 0105, stop -> PAUSE, count_en=0; start -> RUN with no load; stop twice -> IDLE with load_time=preset.
- Same-cycle stop and start rises in RUN -> PAUSE; stop rise coincident with tick in ALARM -> IDLE with no further blink toggle.
